m2_block_scheduler: RTL and testbench

- Top-level sequencer for the Milestone 2 IDCT datapath: fetch S' block (FS), compute T = S'·C (CT), compute S = Cᵀ·T (CS), write S to SRAM (WS).
- Walks all 2400 8x8 blocks: Y 40x30, then U 20x30, then V 20x30.
- Overlaps stages in two alternating phases, gives the SRAM port to exactly one engine at a time, steers the DP-RAM ping-pong bank, and generates per-block SRAM base addresses.

---
 rtl/m2_block_scheduler.sv | 249 ++++++++++++++++++++++++
 tb/tb_m2_block_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m2_block_scheduler.sv
// m2_block_scheduler: sequences fetch (FS), column/row IDCT (CT/CS) and write (WS) over the 2400 Y/U/V blocks.
// Define M2_PERF_CNT_EN to add the stall_cycles counter output.
module m2_block_scheduler #(
   parameter int Y_COLS   = 40,
   parameter int UV_COLS  = 20,
   parameter int ROWS     = 30,
   parameter int PRE_BASE = 76800,
   parameter int U_BASE   = 38400,
   parameter int V_BASE   = 57600
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        Start,
   output logic        Done,
   output logic        busy,
   output logic        fs_start,
   output logic        ct_start,
   output logic        cs_start,
   output logic        ws_start,
   input  logic        fs_done,
   input  logic        ct_done,
   input  logic        cs_done,
   input  logic        ws_done,
   output logic [17:0] fs_base,
   output logic [8:0]  fs_stride,
   output logic [17:0] ws_base,
   output logic [7:0]  ws_stride,
   output logic        sram_owner,
   output logic        fs_bank,
   output logic [11:0] blk_fetched
`ifdef M2_PERF_CNT_EN
   ,
   output logic [23:0] stall_cycles
`endif
);

   localparam logic [11:0] TOTAL_BLKS = 12'(ROWS * (Y_COLS + 2 * UV_COLS));

   typedef enum logic [2:0] {
      S_IDLE, S_LI_FS, S_LI_CT, S_M1, S_M2, S_LO_CS, S_LO_WS, S_FIN
   } state_t;

   state_t      r_state, w_state_nx;
   logic [3:0]  r_flags, r_starts, w_mask, w_cap;
   logic        r_first, r_done, r_busy, r_owner, r_bank;
   logic        w_all, w_enter, w_go;
   logic [12:0] r_fpos, r_wpos, w_fpos_nx, w_wpos_nx;
   logic [17:0] r_fs_base, r_ws_base;
   logic [8:0]  r_fs_stride;
   logic [7:0]  r_ws_stride;
   logic [11:0] r_blk;

   // Engines owned by each phase, bit order {ws, cs, ct, fs}
   function automatic logic [3:0] f_mask(input state_t s);
      case (s)
         S_LI_FS: return 4'b0001;
         S_LI_CT: return 4'b0010;
         S_M1:    return 4'b0101;
         S_M2:    return 4'b1010;
         S_LO_CS: return 4'b0100;
         S_LO_WS: return 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [12:0] f_next(input logic [12:0] pos);
      logic [1:0] p;
      logic [4:0] r;
      logic [5:0] c;
      logic [5:0] last;
      {p, r, c} = pos;
      last = (p == 2'd0) ? 6'(Y_COLS - 1) : 6'(UV_COLS - 1);
      if (c != last) begin
         c = c + 6'd1;
      end else begin
         c = 6'd0;
         if (r != 5'(ROWS - 1)) begin
            r = r + 5'd1;
         end else begin
            r = 5'd0;
            p = (p == 2'd2) ? 2'd0 : p + 2'd1;
         end
      end
      return {p, r, c};
   endfunction

   function automatic logic [8:0] f_fs_stride(input logic [1:0] p);
      return (p == 2'd0) ? 9'd320 : 9'd160;
   endfunction

   function automatic logic [7:0] f_ws_stride(input logic [1:0] p);
      return (p == 2'd0) ? 8'd160 : 8'd80;
   endfunction

   function automatic logic [17:0] f_fs_base(input logic [12:0] pos);
      logic [17:0] base;
      case (pos[12:11])
         2'd0:    base = 18'(PRE_BASE);
         2'd1:    base = 18'(PRE_BASE + 76800);
         default: base = 18'(PRE_BASE + 115200);
      endcase
      return base + ((18'(pos[10:6]) * 18'(f_fs_stride(pos[12:11]))) << 3'd3) + (18'(pos[5:0]) << 3'd3);
   endfunction

   function automatic logic [17:0] f_ws_base(input logic [12:0] pos);
      logic [17:0] base;
      case (pos[12:11])
         2'd0:    base = 18'd0;
         2'd1:    base = 18'(U_BASE);
         default: base = 18'(V_BASE);
      endcase
      return base + ((18'(pos[10:6]) * 18'(f_ws_stride(pos[12:11]))) << 3'd3) + (18'(pos[5:0]) << 3'd2);
   endfunction

   // Done pulses count only for engines of the current phase, never in its start cycle, once each
   assign w_mask    = f_mask(r_state);
   assign w_cap     = {ws_done, cs_done, ct_done, fs_done} & w_mask & ~r_flags & {4{~r_first}};
   assign w_all     = (w_mask != 4'd0) && ((r_flags & w_mask) == w_mask);
   assign w_enter   = (w_state_nx != r_state);
   assign w_go      = (r_state == S_IDLE) && Start;
   assign w_fpos_nx = f_next(r_fpos);
   assign w_wpos_nx = f_next(r_wpos);

   // Phase sequencing
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE:  w_state_nx = Start ? S_LI_FS : S_IDLE;
         S_LI_FS: w_state_nx = w_all ? S_LI_CT : S_LI_FS;
         S_LI_CT: w_state_nx = w_all ? S_M1 : S_LI_CT;
         S_M1:    w_state_nx = w_all ? S_M2 : S_M1;
         S_M2: begin
            if (!w_all)                     w_state_nx = S_M2;
            else if (r_blk == TOTAL_BLKS)   w_state_nx = S_LO_CS;
            else                            w_state_nx = S_M1;
         end
         S_LO_CS: w_state_nx = w_all ? S_LO_WS : S_LO_CS;
         S_LO_WS: w_state_nx = w_all ? S_FIN : S_LO_WS;
         S_FIN:   w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   // State register, sticky done flags and one-cycle start/Done pulses
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_state  <= S_IDLE;
         r_first  <= 1'b0;
         r_flags  <= 4'd0;
         r_starts <= 4'd0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_first  <= w_enter;
         r_flags  <= w_enter ? 4'd0 : (r_flags | w_cap);
         r_starts <= w_enter ? f_mask(w_state_nx) : 4'd0;
         r_done   <= w_enter && (w_state_nx == S_FIN);
         r_busy   <= (w_state_nx != S_IDLE);
      end
   end

   // SRAM ownership and DP-RAM ping-pong bank
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_owner <= 1'b0;
         r_bank  <= 1'b0;
      end else begin
         if (w_go)
            r_bank <= 1'b0;
         else if (w_enter && (r_state == S_M1 || r_state == S_LI_CT))
            r_bank <= ~r_bank;
         else
            r_bank <= r_bank;
         if (w_enter && (w_state_nx == S_LI_FS || w_state_nx == S_M1))
            r_owner <= 1'b0;
         else if (w_enter && (w_state_nx == S_M2 || w_state_nx == S_LO_WS))
            r_owner <= 1'b1;
         else
            r_owner <= r_owner;
      end
   end

   // Fetch/write block counters; bases are computed from the advanced counter so they lead the next start
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_fpos      <= 13'd0;
         r_wpos      <= 13'd0;
         r_fs_base   <= 18'(PRE_BASE);
         r_fs_stride <= 9'd320;
         r_ws_base   <= 18'd0;
         r_ws_stride <= 8'd160;
         r_blk       <= 12'd0;
      end else if (w_go) begin
         r_fpos      <= 13'd0;
         r_wpos      <= 13'd0;
         r_fs_base   <= 18'(PRE_BASE);
         r_fs_stride <= 9'd320;
         r_ws_base   <= 18'd0;
         r_ws_stride <= 8'd160;
         r_blk       <= 12'd0;
      end else begin
         if (w_cap[0]) begin
            r_fpos      <= w_fpos_nx;
            r_fs_base   <= f_fs_base(w_fpos_nx);
            r_fs_stride <= f_fs_stride(w_fpos_nx[12:11]);
            r_blk       <= (r_blk == TOTAL_BLKS) ? r_blk : r_blk + 12'd1;
         end
         if (w_cap[3]) begin
            r_wpos      <= w_wpos_nx;
            r_ws_base   <= f_ws_base(w_wpos_nx);
            r_ws_stride <= f_ws_stride(w_wpos_nx[12:11]);
         end
      end
   end

`ifdef M2_PERF_CNT_EN
   logic [23:0] r_stall;
   logic [3:0]  w_held;
   logic        w_one;
   assign w_held = r_flags & w_mask;
   assign w_one  = (r_state == S_M1 || r_state == S_M2) && (w_held != 4'd0)
                   && ((w_held & (w_held - 4'd1)) == 4'd0);

   // Cycles an overlapped phase waits on its slower engine
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn)                               r_stall <= 24'd0;
      else if (w_go)                             r_stall <= 24'd0;
      else if (w_one && (r_stall != {24{1'b1}})) r_stall <= r_stall + 24'd1;
      else                                       r_stall <= r_stall;
   end
   assign stall_cycles = r_stall;
`endif

   assign Done        = r_done;
   assign busy        = r_busy;
   assign fs_start    = r_starts[0];
   assign ct_start    = r_starts[1];
   assign cs_start    = r_starts[2];
   assign ws_start    = r_starts[3];
   assign fs_base     = r_fs_base;
   assign fs_stride   = r_fs_stride;
   assign ws_base     = r_ws_base;
   assign ws_stride   = r_ws_stride;
   assign sram_owner  = r_owner;
   assign fs_bank     = r_bank;
   assign blk_fetched = r_blk;

endmodule

// File: tb/tb_m2_block_scheduler.sv
// tb_m2_block_scheduler: randomized engine models plus a queue scoreboard checked against a block-index reference model.
module tb_m2_block_scheduler;

   logic        Clock, Resetn, Start, Done, busy;
   logic        fs_start, ct_start, cs_start, ws_start;
   logic        fs_done, ct_done, cs_done, ws_done;
   logic [17:0] fs_base, ws_base;
   logic [8:0]  fs_stride;
   logic [7:0]  ws_stride;
   logic        sram_owner, fs_bank;
   logic [11:0] blk_fetched;
`ifdef M2_PERF_CNT_EN
   logic [23:0] stall_cycles;
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   m2_block_scheduler dut (
      .Clock(Clock), .Resetn(Resetn), .Start(Start), .Done(Done), .busy(busy),
      .fs_start(fs_start), .ct_start(ct_start), .cs_start(cs_start), .ws_start(ws_start),
      .fs_done(fs_done), .ct_done(ct_done), .cs_done(cs_done), .ws_done(ws_done),
      .fs_base(fs_base), .fs_stride(fs_stride), .ws_base(ws_base), .ws_stride(ws_stride),
      .sram_owner(sram_owner), .fs_bank(fs_bank), .blk_fetched(blk_fetched)
`ifdef M2_PERF_CNT_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   typedef struct { int k; int base; int stride; int bank; } exp_t;
   exp_t q_fs[$], q_ct[$], q_cs[$], q_ws[$];
   int   q_done[$];

   int checks = 0, errors = 0;
   int cyc = 0, exp_start_cyc = 0, n_done = 0;
   bit armed = 1'b0;
   int fs_sk, ct_sk, cs_sk, ws_sk, fs_dk, ct_dk, cs_dk, ws_dk;
   int c_fs, c_ct, c_cs, c_ws;
   exp_t e_m;

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   always @(posedge Clock) cyc <= cyc + 1;

   task automatic chk(input string name, input int k, input longint got, input longint want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s k=%0d got %0d expected %0d", name, k, got, want);
      end
   endtask

   task automatic no_entry(input string name);
      checks++;
      errors++;
      $display("FAIL %s pulse with no expected entry at cycle %0d", name, cyc);
   endtask

   // Reference model: block index k -> plane/row/col by plain division
   function automatic int plane_of(input int k);
      return (k < 1200) ? 0 : (k < 1800) ? 1 : 2;
   endfunction
   function automatic int ref_fs_stride(input int k);
      return (plane_of(k) == 0) ? 320 : 160;
   endfunction
   function automatic int ref_ws_stride(input int k);
      return (plane_of(k) == 0) ? 160 : 80;
   endfunction
   function automatic int ref_fs_base(input int k);
      int p = plane_of(k);
      int j = (p == 0) ? k : (p == 1) ? k - 1200 : k - 1800;
      int cols = (p == 0) ? 40 : 20;
      int pre = (p == 0) ? 76800 : (p == 1) ? 153600 : 192000;
      return pre + (j / cols) * 8 * ref_fs_stride(k) + (j % cols) * 8;
   endfunction
   function automatic int ref_ws_base(input int k);
      int p = plane_of(k);
      int j = (p == 0) ? k : (p == 1) ? k - 1200 : k - 1800;
      int cols = (p == 0) ? 40 : 20;
      int post = (p == 0) ? 0 : (p == 1) ? 38400 : 57600;
      return post + (j / cols) * 8 * ref_ws_stride(k) + (j % cols) * 4;
   endfunction

   // fs_bank flips after LI_CT and after each M1, so FS(k) sees k%2 and CT(k>0) sees the flipped value
   function automatic exp_t mk_fs(input int k);
      exp_t e;
      e.k = k; e.base = ref_fs_base(k); e.stride = ref_fs_stride(k); e.bank = k % 2;
      return e;
   endfunction
   function automatic exp_t mk_ct(input int k);
      exp_t e;
      e.k = k; e.base = 0; e.stride = 0; e.bank = (k == 0) ? 0 : (k + 1) % 2;
      return e;
   endfunction
   function automatic exp_t mk_ws(input int k);
      exp_t e;
      e.k = k; e.base = ref_ws_base(k); e.stride = ref_ws_stride(k); e.bank = 0;
      return e;
   endfunction

   // Monitor: pops expected entries whenever the DUT pulses a start or Done
   always @(negedge Clock) begin
      if (Resetn && armed) begin
         if (fs_start || ct_start || cs_start || ws_start || Done)
            chk("phase_timing", -1, cyc, exp_start_cyc);
         if (fs_start) begin
            if (q_fs.size() == 0) no_entry("fs_start");
            else begin
               e_m = q_fs.pop_front();
               chk("fs_base", e_m.k, fs_base, e_m.base);
               chk("fs_stride", e_m.k, fs_stride, e_m.stride);
               chk("fs_bank", e_m.k, fs_bank, e_m.bank);
               chk("fs_owner", e_m.k, sram_owner, 0);
               chk("blk_fetched", e_m.k, blk_fetched, e_m.k);
               chk("busy", e_m.k, busy, 1);
            end
         end
         if (ct_start) begin
            if (q_ct.size() == 0) no_entry("ct_start");
            else begin
               e_m = q_ct.pop_front();
               chk("ct_bank", e_m.k, fs_bank, e_m.bank);
            end
         end
         if (cs_start) begin
            if (q_cs.size() == 0) no_entry("cs_start");
            else e_m = q_cs.pop_front();
         end
         if (ws_start) begin
            if (q_ws.size() == 0) no_entry("ws_start");
            else begin
               e_m = q_ws.pop_front();
               chk("ws_base", e_m.k, ws_base, e_m.base);
               chk("ws_stride", e_m.k, ws_stride, e_m.stride);
               chk("ws_owner", e_m.k, sram_owner, 1);
            end
         end
         if (Done) begin
            if (q_done.size() == 0) no_entry("Done");
            else begin
               void'(q_done.pop_front());
               chk("blk_fetched_at_done", 2400, blk_fetched, 2400);
            end
            n_done++;
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"}, 0, busy, 0);
      chk({tag, "_Done"}, 0, Done, 0);
      chk({tag, "_starts"}, 0, {fs_start, ct_start, cs_start, ws_start}, 0);
      chk({tag, "_owner"}, 0, sram_owner, 0);
      chk({tag, "_bank"}, 0, fs_bank, 0);
      chk({tag, "_blk"}, 0, blk_fetched, 0);
      chk({tag, "_fs_base"}, 0, fs_base, 76800);
      chk({tag, "_fs_stride"}, 0, fs_stride, 320);
      chk({tag, "_ws_base"}, 0, ws_base, 0);
      chk({tag, "_ws_stride"}, 0, ws_stride, 160);
   endtask

   task automatic clear_model();
      q_fs.delete(); q_ct.delete(); q_cs.delete(); q_ws.delete(); q_done.delete();
      fs_sk = 0; ct_sk = 0; cs_sk = 0; ws_sk = 0;
      fs_dk = 0; ct_dk = 0; cs_dk = 0; ws_dk = 0;
      c_fs = 0; c_ct = 0; c_cs = 0; c_ws = 0;
      n_done = 0;
   endtask

   task automatic start_frame();
      @(posedge Clock); #1;
      clear_model();
      Start = 1'b1;
      q_fs.push_back(mk_fs(0));
      exp_start_cyc = cyc + 1;
      armed = 1'b1;
   endtask

   // Engine models: latency picked when each start is seen, done pulsed for one cycle
   task automatic run_frame(input int abort_at, output bit aborted);
      int  budget = 0, lat;
      bit  fin = 1'b0, restart = 1'b0, stray = 1'b0;
      aborted = 1'b0;
      while (!fin && !aborted && budget < 60000) begin
         @(negedge Clock);
         budget++;
         if (Done) fin = 1'b1;
         if (fs_start && cs_start) begin
            if (PERF) begin
               lat = $urandom_range(3, 1); c_cs = lat; c_fs = lat + 10;
            end else if (fs_sk == 5) begin c_cs = 2;  c_fs = 52; end
            else if (fs_sk == 6)     begin c_cs = 52; c_fs = 2;  end
            else if (fs_sk == 7)     begin c_cs = 3;  c_fs = 3;  end
            else if (fs_sk == 8)     begin c_cs = 3;  c_fs = 4;  end
            else begin c_cs = $urandom_range(4, 1); c_fs = $urandom_range(4, 1); end
            if (fs_sk == 8) stray = 1'b1;
            if (fs_sk == 300 && abort_at < 0) restart = 1'b1;
            fs_sk++; cs_sk++;
         end else begin
            if (fs_start) begin c_fs = $urandom_range(4, 1); fs_sk++; end
            if (cs_start) begin c_cs = $urandom_range(4, 1); cs_sk++; end
         end
         if (ws_start && ws_sk == abort_at) aborted = 1'b1;
         if (ct_start && ws_start) begin
            lat = $urandom_range(4, 1); c_ct = lat;
            c_ws = PERF ? lat : $urandom_range(4, 1);
            ct_sk++; ws_sk++;
         end else begin
            if (ct_start) begin c_ct = $urandom_range(4, 1); ct_sk++; end
            if (ws_start) begin c_ws = $urandom_range(4, 1); ws_sk++; end
         end
         if (!fin && !aborted) begin
            @(posedge Clock); #1;
            Start = restart; restart = 1'b0;
            fs_done = 1'b0; ct_done = 1'b0; cs_done = 1'b0; ws_done = stray; stray = 1'b0;
            if (c_fs > 0) begin
               c_fs--;
               if (c_fs == 0) begin
                  fs_done = 1'b1; exp_start_cyc = cyc + 2;
                  q_ct.push_back(mk_ct(fs_dk));
                  if (fs_dk < 2399) q_fs.push_back(mk_fs(fs_dk + 1));
                  fs_dk++;
               end
            end
            if (c_ct > 0) begin
               c_ct--;
               if (c_ct == 0) begin
                  ct_done = 1'b1; exp_start_cyc = cyc + 2;
                  q_cs.push_back(mk_ct(ct_dk)); ct_dk++;
               end
            end
            if (c_cs > 0) begin
               c_cs--;
               if (c_cs == 0) begin
                  cs_done = 1'b1; exp_start_cyc = cyc + 2;
                  q_ws.push_back(mk_ws(cs_dk)); cs_dk++;
               end
            end
            if (c_ws > 0) begin
               c_ws--;
               if (c_ws == 0) begin
                  ws_done = 1'b1; exp_start_cyc = cyc + 2;
                  if (ws_dk == 2399) q_done.push_back(ws_dk);
                  ws_dk++;
               end
            end
         end
      end
      if (!fin && !aborted) begin
         checks++; errors++;
         $display("FAIL frame_timeout no Done or abort point after %0d cycles", budget);
      end
   endtask

   initial begin
      bit ab;
      Resetn = 1'b1; Start = 1'b0;
      fs_done = 1'b0; ct_done = 1'b0; cs_done = 1'b0; ws_done = 1'b0;
      clear_model();
      #2 Resetn = 1'b0;
      #21;
      check_reset_outputs("reset");
      @(posedge Clock); #1 Resetn = 1'b1;
      repeat (3) @(posedge Clock);

      // Frame aborted by reset while WS(500) is running in M2
      start_frame();
      run_frame(500, ab);
      chk("abort_reached", 500, ab, 1);
      #2;
      Resetn = 1'b0; armed = 1'b0;
      fs_done = 1'b0; ct_done = 1'b0; cs_done = 1'b0; ws_done = 1'b0; Start = 1'b0;
      #1;
      check_reset_outputs("abort");
      clear_model();
      @(posedge Clock); #1 Resetn = 1'b1;
      repeat (2) @(posedge Clock);

      // Full frame
      start_frame();
      run_frame(-1, ab);
      repeat (3) @(negedge Clock);
      chk("busy_after_done", 2400, busy, 0);
      chk("done_count", 2400, n_done, 1);
      chk("blk_fetched_final", 2400, blk_fetched, 2400);
      chk("pending_fs", 2400, q_fs.size(), 0);
      chk("pending_ws", 2400, q_ws.size() + q_cs.size() + q_ct.size() + q_done.size(), 0);
`ifdef M2_PERF_CNT_EN
      chk("stall_cycles", 2400, stall_cycles, 10 * 2399);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
